// File: rtl/data_mem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding,
// full-word byte-enable constant and the default ack timeout.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [3:0] BE_WORD         = 4'b1111;
    localparam int         TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/data_mem_bridge_timeout_ctr.sv
// Ack-wait counter: cleared while idle, counts bus cycles while enabled,
// and flags expiry on the cycle it holds TIMEOUT-1. It stops counting at
// expiry, so the 8-bit register never wraps for TIMEOUT in 1..255.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expire_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

    // Next count: clear has priority, then increment until expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Converts the core's single-cycle MemWrite/MemRead into a req/ack bus
// transaction, stalls the core until ack or timeout, and returns load data.
//
// Handshake: bus_req is high for every REQ cycle and the bus_we/addr/wdata/be
// fields are constant for that whole window; the memory answers with a
// single-cycle bus_ack (bus_rdata valid with it). An ack seen outside REQ is
// ignored, and bus_req always drops for at least one DONE and one IDLE cycle
// between transactions.
module data_mem_bridge
    import mem_bus_pkg::*;
#(
    parameter int          TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [31:0] RD_ERR  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        start;
    logic        in_req;
    logic        expired;
    logic        timeout;
    logic        stall_core;

    assign start   = (state_q == ST_IDLE) && (mem_write || mem_read);
    assign in_req  = (state_q == ST_REQ);
    assign timeout = in_req && !bus_ack && expired;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .clr_i    (!in_req),
        .en_i     (in_req),
        .expire_o (expired)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: DONE always returns to IDLE so the core commits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_write || mem_read) state_d = ST_REQ;
            ST_REQ:  if (bus_ack || expired)    state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the request cycle itself stalls; DONE releases the core.
    always_comb begin
        bus_req    = 1'b0;
        stall_core = 1'b0;
        case (state_q)
            ST_IDLE: stall_core = mem_write || mem_read;
            ST_REQ: begin
                bus_req    = 1'b1;
                stall_core = 1'b1;
            end
            default: begin
                bus_req    = 1'b0;
                stall_core = 1'b0;
            end
        endcase
    end

    // Reset releases the core at once rather than waiting for the state to settle.
    assign stall = stall_core && !reset;

    // Capture on start (write wins a simultaneous request), load data on ack or timeout.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (start) begin
            we_d    = mem_write;
            addr_d  = addr;
            wdata_d = wdata;
            be_d    = mem_write ? be : BE_WORD;
        end
        if (in_req && bus_ack && !we_q) begin
            rdata_d = bus_rdata;
        end
        if (timeout) begin
            err_d = 1'b1;
            if (!we_q) begin
                rdata_d = RD_ERR;
            end
        end
    end

    // Capture, read-data and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus_we    = we_q;
    assign bus_addr  = addr_q & 32'hFFFF_FFFC;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign rdata     = rdata_q;
    assign bus_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge with a bus-transaction scoreboard.
module tb_data_mem_bridge;
    import mem_bus_pkg::*;

    localparam int          TO  = 4;
    localparam logic [31:0] RDE = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write, mem_read;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        stall, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int illegal_cnt = 0;

    // {we, word addr, be, wdata}
    logic [68:0] exp_q[$];

    data_mem_bridge #(
        .TIMEOUT (TO),
        .RD_ERR  (RDE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .rdata     (rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one core access starting in an IDLE cycle; memory acks on the
    // ack_cyc-th REQ cycle (0 = never). Returns in the DONE cycle.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input int ack_cyc, input logic [31:0] rd,
                          output int stall_n, output int req_n);
        logic done;
        mem_write = w;
        mem_read  = r;
        addr      = a;
        wdata     = d;
        be        = b;
        exp_q.push_back({w, a[31:2], 2'b00, (w ? b : 4'hF), d});
        stall_n = 0;
        req_n   = 0;
        done    = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stall_n++;
            if (bus_req) req_n++;
            if (bus_req && req_n == ack_cyc) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            @(posedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom();
        end
        check("access_completes", done, 1'b1);
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    // Scoreboard: each rising bus_req consumes one expected transaction.
    logic        req_prev = 1'b0;
    logic        seen_first = 1'b0;
    int          low_run = 0;
    logic [68:0] cur = '0;
    always @(negedge clk) begin
        if (bus_req && !req_prev) begin
            if (seen_first) check("req_gap_ge2", low_run >= 2, 1'b1);
            seen_first = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_req", 1'b1, 1'b0);
            end else begin
                cur = exp_q.pop_front();
                check("bus_we", bus_we, cur[68]);
                check("bus_addr", bus_addr, cur[67:36]);
                check("bus_be", bus_be, cur[35:32]);
                if (cur[68]) check("bus_wdata", bus_wdata, cur[31:0]);
            end
        end else if (bus_req) begin
            check("bus_addr_stable", bus_addr, cur[67:36]);
        end
        if (bus_req) low_run = 0;
        else low_run++;
        req_prev = bus_req;
    end

    // Flag simultaneous store and load requests as illegal stimulus.
    always @(negedge clk) begin
        if (!reset && dbg_state == ST_IDLE && mem_write && mem_read) begin
            illegal_cnt++;
            $display("note: simultaneous mem_write and mem_read, write takes priority");
        end
    end

    int sn, rn;

    initial begin
        reset = 1'b1;
        mem_write = 1'b0; mem_read = 1'b0;
        addr = '0; wdata = '0; be = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #2;
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", bus_be, 4'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // sb to byte 3 of word 0x100, ack on the second REQ cycle.
        access(1'b1, 1'b0, 32'h103, 32'hAB00_0000, 4'b1000, 2, 32'h0, sn, rn);
        check("sb_stall_cycles", sn, 3);
        check("sb_req_cycles", rn, 2);
        check("sb_done_state", dbg_state, ST_DONE);
        check("sb_done_req", bus_req, 1'b0);
        check("sb_rdata_untouched", rdata, 32'h0);
        next_cycle();
        check("sb_idle_state", dbg_state, ST_IDLE);

        // lw with ack on the first REQ cycle: minimum two stalled cycles.
        access(1'b0, 1'b1, 32'h200, 32'h0, 4'b0000, 1, 32'hCAFE_F00D, sn, rn);
        check("lw_stall_cycles", sn, 2);
        check("lw_rdata_done", rdata, 32'hCAFE_F00D);
        next_cycle();
        check("lw_rdata_held1", rdata, 32'hCAFE_F00D);
        next_cycle();
        check("lw_rdata_held2", rdata, 32'hCAFE_F00D);

        // Read with no ack: aborts after TO REQ cycles.
        access(1'b0, 1'b1, 32'h208, 32'h0, 4'b0000, 0, 32'h0, sn, rn);
        check("to_req_cycles", rn, TO);
        check("to_stall_cycles", sn, TO + 1);
        check("to_bus_err", bus_err, 1'b1);
        check("to_rdata", rdata, RDE);
        check("to_done_req", bus_req, 1'b0);
        next_cycle();

        // Good write after timeout; error stays sticky, rdata untouched.
        access(1'b1, 1'b0, 32'h10, 32'h1234_5678, 4'b1111, $urandom_range(1, 3), 32'h0, sn, rn);
        check("post_to_bus_err", bus_err, 1'b1);
        check("post_to_rdata", rdata, RDE);
        next_cycle();

        // Back-to-back sw then lw.
        access(1'b1, 1'b0, 32'h400, 32'h1111_2222, 4'b1111, 1, 32'h0, sn, rn);
        check("b2b_sw_done", dbg_state, ST_DONE);
        next_cycle();
        access(1'b0, 1'b1, 32'h404, 32'h0, 4'b0000, 2, 32'h0BAD_F00D, sn, rn);
        check("b2b_lw_done", dbg_state, ST_DONE);
        check("b2b_lw_rdata", rdata, 32'h0BAD_F00D);
        next_cycle();
        check("b2b_queue_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a REQ cycle.
        mem_read = 1'b1;
        addr = 32'h300;
        wdata = 32'h0;
        exp_q.push_back({1'b0, 32'h300, 4'hF, 32'h0});
        next_cycle();
        check("ar_in_req", bus_req, 1'b1);
        next_cycle();
        #3;
        reset = 1'b1;
        mem_read = 1'b0;
        #1;
        check("ar_bus_req", bus_req, 1'b0);
        check("ar_stall", stall, 1'b0);
        check("ar_bus_err", bus_err, 1'b0);
        check("ar_state", dbg_state, ST_IDLE);
        next_cycle();
        reset = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h7777_7777;
        next_cycle();
        bus_ack = 1'b0;
        check("ar_late_ack_state", dbg_state, ST_IDLE);
        check("ar_late_ack_rdata", rdata, 32'h0);
        check("ar_late_ack_req", bus_req, 1'b0);
        next_cycle();
        check("ar_stays_idle", dbg_state, ST_IDLE);

        // Simultaneous requests: only the write is issued.
        access(1'b1, 1'b1, 32'h44, 32'h0000_0055, 4'b0001, 1, 32'h5A5A_5A5A, sn, rn);
        check("both_done", dbg_state, ST_DONE);
        check("both_rdata_untouched", rdata, 32'h0);
        next_cycle();
        next_cycle();
        check("both_no_second_req", bus_req, 1'b0);

        check("final_queue_empty", exp_q.size(), 0);
        check("illegal_flagged", illegal_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
